// File: rtl/game_pkg.sv
// Shared types and constants for the game sequencer.
// Build option: SCORE_BCD_EN selects a 4-digit packed BCD score instead of binary.
package game_pkg;

  localparam int NUM_BLOCKS = 15;
  localparam int SCORE_W    = 16;

  localparam logic [SCORE_W-1:0] SCORE_MAX_BIN = 16'hFFFF;
  localparam logic [SCORE_W-1:0] SCORE_MAX_BCD = 16'h9999;

  localparam logic [NUM_BLOCKS-1:0] BLOCKS_ALL = {NUM_BLOCKS{1'b1}};

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SERVE       = 3'd1,
    ST_PLAY        = 3'd2,
    ST_MISS        = 3'd3,
    ST_LEVEL_CLEAR = 3'd4,
    ST_GAME_OVER   = 3'd5
  } state_e;

endpackage

// File: rtl/score_accum.sv
// Counts the blocks hit this cycle and adds that count to the score,
// saturating instead of wrapping.
// Build option: SCORE_BCD_EN -> packed BCD add saturating at 9999,
// otherwise binary add saturating at 65535.
module score_accum
  import game_pkg::*;
(
  input  logic [SCORE_W-1:0]    score_in,
  input  logic [NUM_BLOCKS-1:0] hits,
  output logic [SCORE_W-1:0]    score_out
);

  logic [3:0] hit_cnt;

  // Population count of the newly hit blocks (0..15 fits in 4 bits).
  always_comb begin
    hit_cnt = 4'd0;
    for (int i = 0; i < NUM_BLOCKS; i++) begin
      hit_cnt = hit_cnt + {3'b000, hits[i]};
    end
  end

`ifdef SCORE_BCD_EN
  logic [3:0] add_ones;
  logic [3:0] add_tens;
  logic [4:0] d0, d1, d2, d3;
  logic       c0, c1, c2, c3;

  // Split the count into BCD digits, then ripple a per-digit decimal carry;
  // a carry out of the thousands digit means the result passed 9999.
  always_comb begin
    add_tens = (hit_cnt >= 4'd10) ? 4'd1 : 4'd0;
    add_ones = (hit_cnt >= 4'd10) ? (hit_cnt - 4'd10) : hit_cnt;

    d0 = {1'b0, score_in[3:0]} + {1'b0, add_ones};
    c0 = (d0 > 5'd9);
    if (c0) d0 = d0 - 5'd10;

    d1 = {1'b0, score_in[7:4]} + {1'b0, add_tens} + {4'b0000, c0};
    c1 = (d1 > 5'd9);
    if (c1) d1 = d1 - 5'd10;

    d2 = {1'b0, score_in[11:8]} + {4'b0000, c1};
    c2 = (d2 > 5'd9);
    if (c2) d2 = d2 - 5'd10;

    d3 = {1'b0, score_in[15:12]} + {4'b0000, c2};
    c3 = (d3 > 5'd9);
    if (c3) d3 = d3 - 5'd10;

    if (c3) score_out = SCORE_MAX_BCD;
    else    score_out = {d3[3:0], d2[3:0], d1[3:0], d0[3:0]};
  end
`else
  logic [SCORE_W:0] sum;

  // Binary add with one extra bit to catch overflow, then clamp.
  always_comb begin
    sum = {1'b0, score_in} + {{(SCORE_W-3){1'b0}}, hit_cnt};
    if (sum[SCORE_W]) score_out = SCORE_MAX_BIN;
    else              score_out = sum[SCORE_W-1:0];
  end
`endif

endmodule

// File: rtl/game_sequencer.sv
// Breakout-style game sequencer: serve/play/miss/level-clear/game-over flow,
// block bookkeeping, lives, level and score.
// Build option: SCORE_BCD_EN (score format, handled inside score_accum).
//
//  state       | meaning
//  IDLE        | attract screen, last score shown, waits for launch
//  SERVE       | ball held, counts frame ticks, launch accepted once count full
//  PLAY        | ball live, block hits scored, watches lose
//  MISS        | single clock: drop a life, choose SERVE or GAME_OVER
//  LEVEL_CLEAR | ball held, waits SERVE_TICKS ticks, next level, fresh blocks
//  GAME_OVER   | everything frozen until launch returns to IDLE
module game_sequencer
  import game_pkg::*;
#(
  parameter int LIVES_INIT  = 3,
  parameter int SERVE_TICKS = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_tick,
  input  logic                  launch_btn,
  input  logic                  lose,
  input  logic [NUM_BLOCKS-1:0] block_hit,
  output logic                  ball_rst_n,
  output logic [NUM_BLOCKS-1:0] blocks_alive,
  output logic [1:0]            lives,
  output logic [SCORE_W-1:0]    score,
  output logic [3:0]            level,
  output logic [2:0]            state,
  output logic                  game_over
);

  localparam int CNT_W = (SERVE_TICKS < 2) ? 1 : $clog2(SERVE_TICKS + 1);
  localparam logic [CNT_W-1:0] SERVE_MAX = CNT_W'(SERVE_TICKS);
  localparam logic [1:0]       LIVES_LD  = 2'(LIVES_INIT);

  state_e                state_q, state_d;
  logic                  launch_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [1:0]            lives_q, lives_d;
  logic [SCORE_W-1:0]    score_q, score_d;
  logic [3:0]            level_q, level_d;
  logic [NUM_BLOCKS-1:0] blocks_q, blocks_d;

  logic                  launch;
  logic [NUM_BLOCKS-1:0] newly;
  logic [SCORE_W-1:0]    score_sum;

  // Only a rising edge of the button counts; holding it does nothing more.
  assign launch = launch_btn & ~launch_q;

  // Hits only matter while the ball is live, and only on blocks still standing.
  assign newly = (state_q == ST_PLAY) ? (block_hit & blocks_q) : '0;

  score_accum u_score_accum (
    .score_in  (score_q),
    .hits      (newly),
    .score_out (score_sum)
  );

  // State and datapath registers; reset aborts a game immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      launch_q <= 1'b0;
      cnt_q    <= '0;
      lives_q  <= LIVES_LD;
      score_q  <= '0;
      level_q  <= 4'd1;
      blocks_q <= BLOCKS_ALL;
    end else begin
      state_q  <= state_d;
      launch_q <= launch_btn;
      cnt_q    <= cnt_d;
      lives_q  <= lives_d;
      score_q  <= score_d;
      level_q  <= level_d;
      blocks_q <= blocks_d;
    end
  end

  // Next-state and datapath update for each game phase.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lives_d  = lives_q;
    score_d  = score_q;
    level_d  = level_q;
    blocks_d = blocks_q;

    case (state_q)
      ST_IDLE: begin
        if (launch) begin
          state_d  = ST_SERVE;
          cnt_d    = '0;
          lives_d  = LIVES_LD;
          score_d  = '0;
          level_d  = 4'd1;
          blocks_d = BLOCKS_ALL;
        end
      end
      ST_SERVE: begin
        if (launch && (cnt_q == SERVE_MAX)) begin
          state_d = ST_PLAY;
          cnt_d   = '0;
        end else if (frame_tick && (cnt_q != SERVE_MAX)) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PLAY: begin
        cnt_d    = '0;
        blocks_d = blocks_q & ~newly;
        score_d  = score_sum;
        // Clearing the last block wins over a simultaneous lose.
        if (blocks_d == '0)  state_d = ST_LEVEL_CLEAR;
        else if (lose)       state_d = ST_MISS;
      end
      ST_MISS: begin
        lives_d = lives_q - 2'd1;
        state_d = (lives_q == 2'd1) ? ST_GAME_OVER : ST_SERVE;
      end
      ST_LEVEL_CLEAR: begin
        if (cnt_q == SERVE_MAX) begin
          state_d  = ST_SERVE;
          cnt_d    = '0;
          level_d  = (level_q == 4'd15) ? 4'd15 : (level_q + 4'd1);
          blocks_d = BLOCKS_ALL;
        end else if (frame_tick) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_GAME_OVER: begin
        if (launch) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ball_rst_n   = (state_q == ST_PLAY);
  assign game_over    = (state_q == ST_GAME_OVER);
  assign blocks_alive = blocks_q;
  assign lives        = lives_q;
  assign score        = score_q;
  assign level        = level_q;
  assign state        = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed bench for game_sequencer plus direct vectors on score_accum.
// Build option: SCORE_BCD_EN switches the expected score format.
module tb_game_sequencer;
  import game_pkg::*;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic                  frame_tick = 1'b0;
  logic                  launch_btn = 1'b0;
  logic                  lose = 1'b0;
  logic [NUM_BLOCKS-1:0] block_hit = '0;
  logic                  ball_rst_n;
  logic [NUM_BLOCKS-1:0] blocks_alive;
  logic [1:0]            lives;
  logic [SCORE_W-1:0]    score;
  logic [3:0]            level;
  logic [2:0]            state;
  logic                  game_over;

  logic [SCORE_W-1:0]    acc_in = '0;
  logic [NUM_BLOCKS-1:0] acc_hits = '0;
  logic [SCORE_W-1:0]    acc_out;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2,
                         S_MISS = 3'd3, S_LC = 3'd4, S_GO = 3'd5;

`ifdef SCORE_BCD_EN
  localparam logic [15:0] SC14 = 16'h0014;
  localparam logic [15:0] SC15 = 16'h0015;
`else
  localparam logic [15:0] SC14 = 16'd14;
  localparam logic [15:0] SC15 = 16'd15;
`endif

  game_sequencer #(.LIVES_INIT(3), .SERVE_TICKS(60)) dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .launch_btn   (launch_btn),
    .lose         (lose),
    .block_hit    (block_hit),
    .ball_rst_n   (ball_rst_n),
    .blocks_alive (blocks_alive),
    .lives        (lives),
    .score        (score),
    .level        (level),
    .state        (state),
    .game_over    (game_over)
  );

  score_accum u_acc (
    .score_in  (acc_in),
    .hits      (acc_hits),
    .score_out (acc_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      step();
    end
  endtask

  task automatic pulse_launch();
    launch_btn = 1'b1;
    step();
    launch_btn = 1'b0;
    step();
  endtask

  task automatic serve_to_play();
    do_ticks(60);
    pulse_launch();
    checks++;
    if (state !== S_PLAY) begin
      errors++; $display("FAIL serve_to_play state: got %0d expected %0d", state, S_PLAY);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    checks++;
    if ({state, ball_rst_n, game_over} !== {S_IDLE, 1'b0, 1'b0}) begin
      errors++; $display("FAIL reset_ctrl: got st=%0d brn=%b go=%b expected st=0 brn=0 go=0", state, ball_rst_n, game_over);
    end
    checks++;
    if ({blocks_alive, lives, score, level} !== {15'h7FFF, 2'd3, 16'd0, 4'd1}) begin
      errors++; $display("FAIL reset_data: got blk=%h lv=%0d sc=%h lvl=%0d expected 7fff 3 0 1", blocks_alive, lives, score, level);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_start();
    pulse_launch();
    checks++;
    if ({state, ball_rst_n, lives, score, level, blocks_alive} !== {S_SERVE, 1'b0, 2'd3, 16'd0, 4'd1, 15'h7FFF}) begin
      errors++; $display("FAIL start: got st=%0d brn=%b lv=%0d sc=%h lvl=%0d blk=%h expected 1 0 3 0 1 7fff",
                         state, ball_rst_n, lives, score, level, blocks_alive);
    end
  endtask

  task automatic test_serve();
    do_ticks(30);
    pulse_launch();
    checks++;
    if (state !== S_SERVE) begin
      errors++; $display("FAIL early_launch: got %0d expected %0d", state, S_SERVE);
    end
    launch_btn = 1'b1;
    do_ticks(30);
    step();
    checks++;
    if (state !== S_SERVE) begin
      errors++; $display("FAIL held_launch: got %0d expected %0d", state, S_SERVE);
    end
    launch_btn = 1'b0;
    step();
    pulse_launch();
    checks++;
    if ({state, ball_rst_n} !== {S_PLAY, 1'b1}) begin
      errors++; $display("FAIL serve_launch: got st=%0d brn=%b expected 2 1", state, ball_rst_n);
    end
  endtask

  task automatic test_hits();
    block_hit = 15'h0005;
    step();
    block_hit = '0;
    checks++;
    if ({blocks_alive, score} !== {15'h7FFA, 16'd2}) begin
      errors++; $display("FAIL hit_first: got blk=%h sc=%h expected 7ffa 2", blocks_alive, score);
    end
    block_hit = 15'h0005;
    step();
    block_hit = '0;
    checks++;
    if ({blocks_alive, score} !== {15'h7FFA, 16'd2}) begin
      errors++; $display("FAIL hit_repeat: got blk=%h sc=%h expected 7ffa 2", blocks_alive, score);
    end
    block_hit = 15'h3FFA;
    step();
    block_hit = '0;
    checks++;
    if ({blocks_alive, score, state} !== {15'h4000, SC14, S_PLAY}) begin
      errors++; $display("FAIL hit_multi: got blk=%h sc=%h st=%0d expected 4000 %h 2", blocks_alive, score, state, SC14);
    end
  endtask

  task automatic test_miss();
    lose = 1'b1;
    step();
    lose = 1'b0;
    checks++;
    if ({state, ball_rst_n} !== {S_MISS, 1'b0}) begin
      errors++; $display("FAIL miss_state: got st=%0d brn=%b expected 3 0", state, ball_rst_n);
    end
    step();
    checks++;
    if ({state, lives} !== {S_SERVE, 2'd2}) begin
      errors++; $display("FAIL miss_exit: got st=%0d lv=%0d expected 1 2", state, lives);
    end
    block_hit = 15'h4000;
    step();
    block_hit = '0;
    checks++;
    if ({blocks_alive, score} !== {15'h4000, SC14}) begin
      errors++; $display("FAIL hit_in_serve: got blk=%h sc=%h expected 4000 %h", blocks_alive, score, SC14);
    end
    serve_to_play();
  endtask

  task automatic test_level_clear();
    block_hit = 15'h4000;
    lose = 1'b1;
    step();
    block_hit = '0;
    lose = 1'b0;
    checks++;
    if ({state, score, lives, blocks_alive, ball_rst_n} !== {S_LC, SC15, 2'd2, 15'h0000, 1'b0}) begin
      errors++; $display("FAIL clear_and_lose: got st=%0d sc=%h lv=%0d blk=%h brn=%b expected 4 %h 2 0000 0",
                         state, score, lives, blocks_alive, ball_rst_n, SC15);
    end
    do_ticks(59);
    checks++;
    if ({state, level} !== {S_LC, 4'd1}) begin
      errors++; $display("FAIL clear_wait: got st=%0d lvl=%0d expected 4 1", state, level);
    end
    do_ticks(1);
    checks++;
    if ({state, level, blocks_alive} !== {S_SERVE, 4'd2, 15'h7FFF}) begin
      errors++; $display("FAIL clear_done: got st=%0d lvl=%0d blk=%h expected 1 2 7fff", state, level, blocks_alive);
    end
  endtask

  task automatic test_game_over();
    serve_to_play();
    lose = 1'b1;
    step();
    lose = 1'b0;
    step();
    checks++;
    if ({state, lives} !== {S_SERVE, 2'd1}) begin
      errors++; $display("FAIL second_miss: got st=%0d lv=%0d expected 1 1", state, lives);
    end
    serve_to_play();
    lose = 1'b1;
    step();
    lose = 1'b0;
    checks++;
    if (state !== S_MISS) begin
      errors++; $display("FAIL last_miss: got %0d expected %0d", state, S_MISS);
    end
    step();
    do_ticks(2);
    checks++;
    if ({state, lives, game_over, score, level, ball_rst_n} !== {S_GO, 2'd0, 1'b1, SC15, 4'd2, 1'b0}) begin
      errors++; $display("FAIL game_over: got st=%0d lv=%0d go=%b sc=%h lvl=%0d brn=%b expected 5 0 1 %h 2 0",
                         state, lives, game_over, score, level, ball_rst_n, SC15);
    end
    pulse_launch();
    checks++;
    if ({state, game_over, score, ball_rst_n} !== {S_IDLE, 1'b0, SC15, 1'b0}) begin
      errors++; $display("FAIL idle_keep: got st=%0d go=%b sc=%h brn=%b expected 0 0 %h 0", state, game_over, score, ball_rst_n, SC15);
    end
    pulse_launch();
    checks++;
    if ({state, score, lives, level, blocks_alive} !== {S_SERVE, 16'd0, 2'd3, 4'd1, 15'h7FFF}) begin
      errors++; $display("FAIL restart: got st=%0d sc=%h lv=%0d lvl=%0d blk=%h expected 1 0 3 1 7fff",
                         state, score, lives, level, blocks_alive);
    end
  endtask

  task automatic test_reset_mid();
    serve_to_play();
    block_hit = 15'h0001;
    lose = 1'b1;
    step();
    block_hit = '0;
    lose = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if ({state, score, blocks_alive, lives, level, ball_rst_n} !== {S_IDLE, 16'd0, 15'h7FFF, 2'd3, 4'd1, 1'b0}) begin
      errors++; $display("FAIL reset_mid: got st=%0d sc=%h blk=%h lv=%0d lvl=%0d brn=%b expected 0 0 7fff 3 1 0",
                         state, score, blocks_alive, lives, level, ball_rst_n);
    end
    step();
    rst = 1'b1;
    step();
  endtask

  task automatic test_accum();
    logic [15:0] ins [4];
    logic [14:0] hs  [4];
    logic [15:0] exp_o [4];
`ifdef SCORE_BCD_EN
    ins = '{16'h9998, 16'h0009, 16'h0095, 16'h9990};
    hs  = '{15'h0003, 15'h0001, 15'h7FFF, 15'h7FFF};
    exp_o = '{16'h9999, 16'h0010, 16'h0110, 16'h9999};
`else
    ins = '{16'd65534, 16'd100, 16'd0, 16'd65530};
    hs  = '{15'h0007, 15'h7FFF, 15'h0000, 15'h0005};
    exp_o = '{16'd65535, 16'd115, 16'd0, 16'd65532};
`endif
    for (int i = 0; i < 4; i++) begin
      acc_in = ins[i];
      acc_hits = hs[i];
      #1;
      checks++;
      if (acc_out !== exp_o[i]) begin
        errors++; $display("FAIL accum[%0d]: in=%h hits=%h got %h expected %h", i, ins[i], hs[i], acc_out, exp_o[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_serve();
    test_hits();
    test_miss();
    test_level_clear();
    test_game_over();
    test_reset_mid();
    test_accum();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
GAME_SEQUENCER -- requirements
Module: game_sequencer

Interface
REQ-001 SHALL have parameter LIVES_INIT, default 3, lives loaded at game start (1..3).
REQ-002 SHALL have parameter SERVE_TICKS, default 60, frame ticks to wait in SERVE and LEVEL_CLEAR before advancing.
REQ-003 SHALL have port clk  input  1  system clock.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port frame_tick  input  1  one-clk pulse at 60 Hz.
REQ-006 SHALL have port launch_btn  input  1  launch/start button, already synchronous to clk, active-high.
REQ-007 SHALL have port lose  input  1  ball fell past the bottom; level, sticky until ball reset.
REQ-008 SHALL have port block_hit  input  15  per-block collision pulses.
REQ-009 SHALL have port ball_rst_n  output  1  active-low hold/reset to the ball datapath.
REQ-010 SHALL have port blocks_alive  output  15  per-block enable, 1 = drawn and collidable.
REQ-011 SHALL have port lives  output  2  remaining lives.
REQ-012 SHALL have port score  output  16  score, binary or 4-digit BCD per REQ-031.
REQ-013 SHALL have port level  output  4  current level, 1..15.
REQ-014 SHALL have port state  output  3  current FSM state encoding.
REQ-015 SHALL have port game_over  output  1  high while in GAME_OVER.

Function
REQ-016 SHALL implement states IDLE, SERVE, PLAY, MISS, LEVEL_CLEAR, GAME_OVER.
REQ-017 SHALL detect launch as a rising edge of launch_btn (registered previous value); launch_btn held high SHALL NOT retrigger.
REQ-018 IDLE: on launch, SHALL load lives=LIVES_INIT, score=0, level=1, blocks_alive=all ones, and go to SERVE.
REQ-019 SERVE: SHALL hold ball_rst_n low, count frame_tick up to SERVE_TICKS (saturating), and go to PLAY on the first launch after the count reaches SERVE_TICKS; earlier launches SHALL be ignored.
REQ-020 PLAY: ball_rst_n SHALL be high; the serve counter SHALL clear on entry.
REQ-021 In PLAY each cycle, newly = block_hit AND blocks_alive; those bits SHALL clear next cycle and score SHALL increase by popcount(newly) (0..15).
REQ-022 block_hit SHALL be ignored in every state other than PLAY.
REQ-023 Score SHALL saturate at 65535 (binary) or 9999 (BCD), never wrap.
REQ-024 PLAY: if blocks_alive AND NOT newly == 0, SHALL go to LEVEL_CLEAR; else if lose is high, SHALL go to MISS.
REQ-025 Last block cleared and lose high in the same cycle SHALL resolve to LEVEL_CLEAR, with the score counted.
REQ-026 MISS: SHALL last exactly one clock with ball_rst_n low, decrement lives, and go to GAME_OVER if lives was 1, else to SERVE.
REQ-027 LEVEL_CLEAR: SHALL hold ball_rst_n low, wait SERVE_TICKS frame ticks, then increment level (saturating at 15), reload blocks_alive to all ones, and go to SERVE.
REQ-028 GAME_OVER: SHALL hold ball_rst_n low, keep score, lives and level frozen, and go to IDLE on launch.
REQ-029 IDLE: ball_rst_n SHALL be low and score SHALL retain the last game's value.

Reset
REQ-030 On rst low, SHALL enter IDLE with ball_rst_n=0, blocks_alive=all ones, lives=LIVES_INIT, score=0, level=1, game_over=0, serve counter=0 and edge register=0; reset mid-game SHALL abort immediately with the same values.

Configuration
REQ-031 Macro SCORE_BCD_EN: defined -> score is four packed BCD digits with per-digit carry, saturating at 9999; undefined -> plain 16-bit binary, saturating at 65535.

Structure
REQ-032 Shared package game_pkg SHALL hold the state enum, NUM_BLOCKS=15, and score maximum constants.
REQ-033 Popcount and saturating add (binary/BCD) SHALL live in sub-module score_accum.

Verification
REQ-034 Reset, then launch: IDLE->SERVE; lives=3, score=0, level=1, blocks_alive=0x7FFF, ball_rst_n=0.
REQ-035 Launch at tick 30 ignored; launch after 60 ticks -> PLAY, ball_rst_n=1.
REQ-036 block_hit=0x0005 in PLAY -> blocks_alive=0x7FFA, score+2; repeat same pulse -> score unchanged.
REQ-037 lose in PLAY with lives=1 -> MISS for 1 clk -> GAME_OVER, lives=0, game_over=1; launch -> IDLE.
REQ-038 Only bit 14 alive, block_hit=0x4000 with lose=1 same cycle -> LEVEL_CLEAR, lives unchanged; after 60 ticks level=2, blocks_alive=0x7FFF, state SERVE.
REQ-039 SCORE_BCD_EN with score=0x9998, two hits -> score=0x9999; binary build at 65534 +3 -> 65535.
